// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
// Bundles the byte-stream handshake and the instruction RAM write port of the
// instruction memory loader.
//   in_valid / in_data / in_ready : byte link, host side drives valid/data
//   wr_en / wr_addr / wr_data     : single-cycle instruction RAM write
//   wr_pc                         : byte address of the written word (trace)
// Modports:
//   master : host/debug link side (sources bytes, observes RAM writes)
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int ADDR_W = 12
) ();
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [31:0]       wr_data;
   logic [31:0]       wr_pc;

   modport master (
      output in_valid,
      output in_data,
      input  in_ready,
      input  wr_en,
      input  wr_addr,
      input  wr_data,
      input  wr_pc
   );

   modport slave (
      input  in_valid,
      input  in_data,
      output in_ready,
      output wr_en,
      output wr_addr,
      output wr_data,
      output wr_pc
   );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Streams bytes from the host/debug link into the instruction RAM. A session
// is a 4-byte big-endian word count N followed by N big-endian data words;
// each completed data word is written to RAM at word index 0, 1, ... N-1.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : one-cycle pulse, begins a session from IDLE/DONE/ERR
//   bus        : imem_loader_if.slave (byte link + RAM write port)
//   busy       : session in progress
//   done       : session finished successfully (sticky until start/reset)
//   error      : session aborted (sticky until start/reset)
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to append a 4-byte
// checksum after the data words. It must equal the XOR of all data words,
// otherwise the session ends in ERR (the words stay written).
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int          DEPTH  = 4096,
   parameter int          ADDR_W = 12,
   parameter logic [31:0] BASE   = 32'h0000_3000
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   imem_loader_if.slave    bus,
   output logic            busy,
   output logic            done,
   output logic            error
);

   // Counters are one bit wider than the address so N == DEPTH is representable.
   localparam int          CNT_W   = ADDR_W + 1;
   localparam logic [31:0] DEPTH_W = 32'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CSUM = 3'd3,
`endif
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   state_t            state_r;
   state_t            state_nx_s;

   logic [1:0]        byte_cnt_r;
   logic [23:0]       shift_r;      // first three bytes of the word in flight
   logic [CNT_W-1:0]  count_r;      // N from the header
   logic [CNT_W-1:0]  idx_r;        // index of the next data word
   logic [CNT_W-1:0]  idx_inc_s;

   logic              in_ready_r;
   logic              wr_en_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [31:0]       wr_data_r;
   logic [31:0]       wr_pc_r;
   logic              busy_r;
   logic              done_r;
   logic              error_r;

   logic              accept_s;
   logic              word_done_s;
   logic              start_ok_s;
   logic              hdr_bad_s;
   logic              last_word_s;
   logic              write_s;
   logic              active_nx_s;
   logic [31:0]       word_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]       acc_r;        // running XOR of the data words
   logic              csum_ok_s;
`endif

   // The word being completed combines the buffered bytes with the live byte.
   assign accept_s    = bus.in_valid & in_ready_r;
   assign word_s      = {shift_r, bus.in_data};
   assign word_done_s = accept_s & (byte_cnt_r == 2'd3);
   assign start_ok_s  = start & ((state_r == ST_IDLE) | (state_r == ST_DONE) | (state_r == ST_ERR));
   assign hdr_bad_s   = (word_s == 32'd0) | (word_s > DEPTH_W);
   assign idx_inc_s   = idx_r + CNT_W'(1);
   assign last_word_s = (idx_inc_s == count_r);
   assign write_s     = word_done_s & (state_r == ST_DATA);
   assign active_nx_s = (state_nx_s == ST_HDR) | (state_nx_s == ST_DATA)
`ifdef IMEM_LOADER_CHECKSUM_EN
                      | (state_nx_s == ST_CSUM)
`endif
                      ;

`ifdef IMEM_LOADER_CHECKSUM_EN
   assign csum_ok_s = (word_s == acc_r);
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state decode; a new header is only accepted from a quiescent state.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE, ST_DONE, ST_ERR: begin
            if (start) begin
               state_nx_s = ST_HDR;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_HDR: begin
            if (word_done_s) begin
               if (hdr_bad_s) begin
                  state_nx_s = ST_ERR;
               end else begin
                  state_nx_s = ST_DATA;
               end
            end else begin
               state_nx_s = ST_HDR;
            end
         end
         ST_DATA: begin
            if (word_done_s && last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               state_nx_s = ST_CSUM;
`else
               state_nx_s = ST_DONE;
`endif
            end else begin
               state_nx_s = ST_DATA;
            end
         end
`ifdef IMEM_LOADER_CHECKSUM_EN
         ST_CSUM: begin
            if (word_done_s) begin
               if (csum_ok_s) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_ERR;
               end
            end else begin
               state_nx_s = ST_CSUM;
            end
         end
`endif
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Byte assembly, header capture and word index.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt_r <= 2'd0;
         shift_r    <= 24'd0;
         count_r    <= '0;
         idx_r      <= '0;
      end else if (start_ok_s) begin
         byte_cnt_r <= 2'd0;
         idx_r      <= '0;
      end else if (accept_s) begin
         byte_cnt_r <= byte_cnt_r + 2'd1;
         shift_r    <= {shift_r[15:0], bus.in_data};
         if (word_done_s && (state_r == ST_HDR) && !hdr_bad_s) begin
            count_r <= word_s[CNT_W-1:0];
            idx_r   <= '0;
         end
         // The index parks at N-1 after the last word; it never wraps.
         if (write_s && !last_word_s) begin
            idx_r <= idx_inc_s;
         end
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // XOR accumulator over the data words of the current session.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= 32'd0;
      end else if (start_ok_s) begin
         acc_r <= 32'd0;
      end else if (write_s) begin
         acc_r <= acc_r ^ word_s;
      end
   end
`endif

   // Registered outputs, derived from the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_ready_r <= 1'b0;
         wr_en_r    <= 1'b0;
         wr_addr_r  <= '0;
         wr_data_r  <= 32'd0;
         wr_pc_r    <= BASE;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
         error_r    <= 1'b0;
      end else begin
         in_ready_r <= active_nx_s;
         busy_r     <= active_nx_s;
         done_r     <= (state_nx_s == ST_DONE);
         error_r    <= (state_nx_s == ST_ERR);
         wr_en_r    <= write_s;
         if (write_s) begin
            wr_addr_r <= idx_r[ADDR_W-1:0];
            wr_data_r <= word_s;
            wr_pc_r   <= BASE + 32'({idx_r[ADDR_W-1:0], 2'b00});
         end
      end
   end

   assign bus.in_ready = in_ready_r;
   assign bus.wr_en    = wr_en_r;
   assign bus.wr_addr  = wr_addr_r;
   assign bus.wr_data  = wr_data_r;
   assign bus.wr_pc    = wr_pc_r;
   assign busy         = busy_r;
   assign done         = done_r;
   assign error        = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Randomized bench for imem_loader. Stimulus pushes the writes the session
// should produce into a scoreboard queue; a negedge monitor pops and checks
// every wr_en pulse. Session status (done/error/busy/in_ready) is checked at
// the points where it must change.
// -----------------------------------------------------------------------------
module tb_imem_loader;
   localparam int          ADDR_W = 12;
   localparam int          DEPTH  = 4096;
   localparam logic [31:0] BASE   = 32'h0000_3000;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic start;
   logic busy;
   logic done;
   logic error;

   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   model_idx;

   exp_t        exp_q[$];
   logic [31:0] data_q[$];
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0] csum_mask;
`endif

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE(BASE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bus   (bus),
      .busy  (busy),
      .done  (done),
      .error (error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor: every write must match the oldest expected write.
   always @(negedge clk) begin
      if (bus.wr_en === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", bus.wr_addr, bus.wr_data);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
            chk("wr_data", bus.wr_data, e.data);
            chk("wr_pc", bus.wr_pc, BASE + 32'(e.addr) * 32'd4);
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_pct);
      int guard;
      while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
         bus.in_valid = 1'b0;
         tick();
      end
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) begin
         chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
      end else begin
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input int gap_pct);
      for (int k = 3; k >= 0; k--) begin
         send_byte(w[8*k +: 8], gap_pct);
      end
   endtask

   // Data word with its expected RAM write.
   task automatic send_data(input logic [31:0] w, input int gap_pct);
      exp_t e;
      e.addr = model_idx[ADDR_W-1:0];
      e.data = w;
      exp_q.push_back(e);
      model_idx++;
      send_word(w, gap_pct);
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_start_idle_link();
      bus.in_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic check_reset_outputs();
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
      chk("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
      chk("rst_wr_data", bus.wr_data, 32'd0);
      chk("rst_wr_pc", bus.wr_pc, BASE);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
   endtask

   // Full session: header hdr, then the words in data_q.
   task automatic load_session(input logic [31:0] hdr, input int gap_pct);
      int          t0;
      int          span;
      logic [31:0] x;
      do_start();
      t0 = cyc;
      chk("start_in_ready", 32'(bus.in_ready), 32'd1);
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_clears_done", 32'(done), 32'd0);
      chk("start_clears_error", 32'(error), 32'd0);
      send_word(hdr, gap_pct);
      if (hdr == 32'd0 || hdr > 32'(DEPTH)) begin
         chk("hdr_error", 32'(error), 32'd1);
         chk("hdr_busy", 32'(busy), 32'd0);
         chk("hdr_in_ready", 32'(bus.in_ready), 32'd0);
         chk("hdr_wr_en", 32'(bus.wr_en), 32'd0);
         chk("hdr_done", 32'(done), 32'd0);
      end else begin
         model_idx = 0;
         x = 32'd0;
         foreach (data_q[i]) begin
            x = x ^ data_q[i];
            send_data(data_q[i], gap_pct);
         end
         span = 4 * (data_q.size() + 1);
         chk("last_wr_en", 32'(bus.wr_en), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
         chk("csum_busy", 32'(busy), 32'd1);
         chk("csum_done", 32'(done), 32'd0);
         tick();
         send_word(x ^ csum_mask, gap_pct);
         span = span + 4;
         chk("csum_done_flag", 32'(done), (csum_mask == 32'd0) ? 32'd1 : 32'd0);
         chk("csum_error_flag", 32'(error), (csum_mask == 32'd0) ? 32'd0 : 32'd1);
         chk("csum_end_busy", 32'(busy), 32'd0);
         chk("csum_end_ready", 32'(bus.in_ready), 32'd0);
         span = span + 1;
`else
         chk("done_flag", 32'(done), 32'd1);
         chk("end_busy", 32'(busy), 32'd0);
         chk("end_in_ready", 32'(bus.in_ready), 32'd0);
         chk("end_error", 32'(error), 32'd0);
`endif
         if (gap_pct == 0) begin
            chk("no_bubbles_cycles", 32'(cyc - t0), 32'(span));
         end
      end
      tick();
      chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
      chk("after_wr_en", 32'(bus.wr_en), 32'd0);
   endtask

   task automatic fill_random(input int n);
      data_q.delete();
      for (int i = 0; i < n; i++) begin
         data_q.push_back($urandom());
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      model_idx    = 0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_mask    = 32'd0;
`endif
      tick();
      tick();
      check_reset_outputs();
      rst_n = 1'b1;
      tick();
      check_reset_outputs();

      // Reference two-word program, no stalls.
      data_q = '{32'h3C08_0001, 32'h3409_0002};
      load_session(32'd2, 0);

      // Header errors: zero, DEPTH+1, large value with high byte set.
      data_q.delete();
      load_session(32'd0, 0);
      load_session(32'd4097, 0);
      load_session(32'h0100_0001, 20);

      // Small random sessions, including N=1.
      fill_random(1);
      load_session(32'd1, 0);
      for (int s = 0; s < 4; s++) begin
         int n;
         n = $urandom_range(20, 1);
         fill_random(n);
         load_session(32'(n), $urandom_range(50));
      end

      // start pulses mid-header and mid-data are ignored.
      do_start();
      model_idx = 0;
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      pulse_start_idle_link();
      chk("ign_start_hdr_busy", 32'(busy), 32'd1);
      send_byte(8'h00, 0);
      send_byte(8'h03, 0);
      send_data(32'hDEAD_BEEF, 0);
      send_byte(8'h12, 0);
      pulse_start_idle_link();
      chk("ign_start_data_busy", 32'(busy), 32'd1);
      send_byte(8'h34, 0);
      send_byte(8'h56, 0);
      send_byte(8'h78, 0);
      model_idx = 1;
      begin
         exp_t e;
         e.addr = 12'd1;
         e.data = 32'h1234_5678;
         exp_q.push_back(e);
      end
      model_idx = 2;
      send_data(32'hCAFE_F00D, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
      chk("ign_start_done", 32'(done), 32'd1);
`endif
      tick();
      chk("ign_start_queue", 32'(exp_q.size()), 32'd0);

      // Reset mid-word while the index is 5.
      do_start();
      model_idx = 0;
      send_word(32'd8, 0);
      for (int i = 0; i < 5; i++) begin
         send_data($urandom(), 0);
      end
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      chk("pre_reset_queue", 32'(exp_q.size()), 32'd0);
      rst_n = 1'b0;
      #2;
      check_reset_outputs();
      tick();
      check_reset_outputs();
      rst_n = 1'b1;
      tick();
      fill_random(1);
      load_session(32'd1, 0);

      // Full memory with a randomly stalling link.
      fill_random(DEPTH);
      load_session(32'(DEPTH), 40);
      chk("full_last_idx", 32'(model_idx), 32'(DEPTH));

`ifdef IMEM_LOADER_CHECKSUM_EN
      // Words 1 and 3: checksum 2 passes, checksum 5 fails.
      data_q = '{32'h0000_0001, 32'h0000_0003};
      csum_mask = 32'd0;
      load_session(32'd2, 0);
      csum_mask = 32'h0000_0007;
      load_session(32'd2, 0);
      csum_mask = 32'd0;
`endif

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
